// File: rtl/dvp_pkg.sv
// dvp_pkg: shared encodings and colour constants for the DVP pattern generator
package dvp_pkg;

    typedef enum logic [1:0] {
        MODE_CNT   = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_GRAD  = 2'd2,
        MODE_FIXED = 2'd3
    } mode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // Index 0 is the leftmost bar
    localparam logic [7:0][15:0] BAR_COLORS = {
        16'h0000, 16'h001F, 16'hF800, 16'hF81F,
        16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
    };

    function automatic logic [15:0] grad_pixel(input logic [5:0] px);
        return {px[4:0], px[5:0], px[4:0]};
    endfunction

endpackage

// File: rtl/dvp_timing_cnt.sv
// dvp_timing_cnt: byte-slot h/v counters with sync and active-region decode
module dvp_timing_cnt #(
    parameter int H_VALID = 640,
    parameter int H_TOTAL = 784,
    parameter int V_SYNC  = 4,
    parameter int V_BACK  = 18,
    parameter int V_VALID = 480,
    parameter int V_FRONT = 8,
    parameter int BPP     = 2
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          i_adv,
    output logic [$clog2(H_TOTAL*BPP)-1:0] o_h_cnt,
    output logic                          o_vs,
    output logic                          o_hv,
    output logic                          o_first,
    output logic                          o_last
);

    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int HW      = $clog2(H_TOTAL * BPP);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL * BPP - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_VALID * BPP);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SY   = VW'(V_SYNC);
    localparam logic [VW-1:0] V_A0   = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_A1   = VW'(V_SYNC + V_BACK + V_VALID - 1);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          w_h_last;
    logic          w_v_last;

    assign w_h_last = (r_h_cnt == H_LAST);
    assign w_v_last = (r_v_cnt == V_LAST);
    assign o_h_cnt  = r_h_cnt;
    assign o_vs     = (r_v_cnt < V_SY);
    assign o_hv     = (r_h_cnt < H_ACT) && (r_v_cnt >= V_A0) && (r_v_cnt <= V_A1);
    assign o_first  = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign o_last   = w_h_last && w_v_last;

    // Advance one byte slot per clock while running; park at the origin otherwise
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!i_adv) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_h_cnt <= w_h_last ? '0 : r_h_cnt + 1'b1;
            if (w_h_last) r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dvp_pattern_gen.sv
// dvp_pattern_gen: DVP camera-style test pattern source with frame sequencing
module dvp_pattern_gen
    import dvp_pkg::*;
#(
    parameter int H_VALID = 640,
    parameter int H_TOTAL = 784,
    parameter int V_SYNC  = 4,
    parameter int V_BACK  = 18,
    parameter int V_VALID = 480,
    parameter int V_FRONT = 8,
    parameter int BPP     = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [15:0] fixed_color,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  data,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam int HW    = $clog2(H_TOTAL * BPP);
    localparam int BAR_W = H_VALID / 8;

    if ((H_VALID % 8 != 0) || (H_VALID >= H_TOTAL) || !(BPP == 1 || BPP == 2)) begin : g_param_check
        $error("dvp_pattern_gen: illegal H_VALID/H_TOTAL/BPP combination");
    end

    state_e        r_state;
    mode_e         r_mode;
    logic [15:0]   r_fixed;
    logic [7:0]    r_bcnt;
    logic          w_adv;
    logic          w_vs;
    logic          w_hv;
    logic          w_first;
    logic          w_last;
    logic [HW-1:0] w_h_cnt;
    mode_e         w_mode;
    logic [15:0]   w_fixed;
    logic [15:0]   w_px;
    logic [2:0]    w_bar;
    logic [15:0]   w_pix;
    logic [7:0]    w_byte;

    // The enabling cycle in IDLE already counts as slot 0 of the new frame
    assign w_adv = (r_state == S_RUN) || enable;

    dvp_timing_cnt #(
        .H_VALID (H_VALID),
        .H_TOTAL (H_TOTAL),
        .V_SYNC  (V_SYNC),
        .V_BACK  (V_BACK),
        .V_VALID (V_VALID),
        .V_FRONT (V_FRONT),
        .BPP     (BPP)
    ) u_timing (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_adv     (w_adv),
        .o_h_cnt   (w_h_cnt),
        .o_vs      (w_vs),
        .o_hv      (w_hv),
        .o_first   (w_first),
        .o_last    (w_last)
    );

    // Pixel and byte selection; frame-start slot sees the live inputs being latched
    always_comb begin
        w_mode  = w_first ? mode_e'(mode) : r_mode;
        w_fixed = w_first ? fixed_color : r_fixed;
        w_px    = 16'((BPP == 2) ? (w_h_cnt >> 1) : w_h_cnt);
        w_bar   = '0;
        for (int i = 1; i < 8; i++) w_bar = (int'(w_px) >= i * BAR_W) ? w_bar + 3'd1 : w_bar;
        w_pix   = (w_mode == MODE_BARS) ? BAR_COLORS[w_bar] :
                  (w_mode == MODE_GRAD) ? grad_pixel(w_px[5:0]) : w_fixed;
        w_byte  = (w_mode == MODE_CNT) ? r_bcnt :
                  (BPP == 2 && !w_h_cnt[0]) ? w_pix[15:8] : w_pix[7:0];
    end

    // Run/idle sequencing, per-frame pattern latch, byte counter and registered outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= S_IDLE;
            r_mode     <= MODE_CNT;
            r_fixed    <= '0;
            r_bcnt     <= '0;
            vsync      <= 1'b0;
            href       <= 1'b0;
            data       <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            if (r_state == S_IDLE) r_state <= enable ? S_RUN : S_IDLE;
            else if (w_last && !enable) r_state <= S_IDLE;
            if (w_adv && w_first) begin
                r_mode  <= mode_e'(mode);
                r_fixed <= fixed_color;
            end
            r_bcnt     <= (w_adv && w_hv) ? r_bcnt + 8'd1 : 8'd0;
            vsync      <= w_adv && w_vs;
            href       <= w_adv && w_hv;
            data       <= (w_adv && w_hv) ? w_byte : 8'd0;
            frame_done <= w_adv && w_last;
            if (w_adv && w_last) frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_dvp_pattern_gen.sv
// tb_dvp_pattern_gen: scoreboard bench for the DVP pattern generator on a reduced frame
module tb_dvp_pattern_gen;

    localparam int HV    = 136;
    localparam int HT    = 144;
    localparam int VS    = 2;
    localparam int VB    = 1;
    localparam int VV    = 2;
    localparam int VF    = 1;
    localparam int BPP   = 2;
    localparam int LINE  = HT * BPP;
    localparam int ACT   = HV * BPP;
    localparam int FRAME = LINE * (VS + VB + VV + VF);

    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] fixed_color = 16'h0000;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic        frame_done;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0]  q_data[$];
    logic [15:0] q_fc[$];

    always #5 sys_clk = ~sys_clk;

    dvp_pattern_gen #(
        .H_VALID (HV), .H_TOTAL (HT), .V_SYNC (VS), .V_BACK (VB),
        .V_VALID (VV), .V_FRONT (VF), .BPP (BPP)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .enable      (enable),
        .mode        (mode),
        .fixed_color (fixed_color),
        .vsync       (vsync),
        .href        (href),
        .data        (data),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int m, input logic [15:0] fc, input int k);
        logic [15:0] p;
        logic [15:0] pix;
        p = 16'(k / 2);
        if (m == 0) return 8'(k);
        pix = (m == 1) ? BARS[(k / 2) / (HV / 8)] : (m == 2) ? {p[4:0], p[5:0], p[4:0]} : fc;
        return (k % 2 == 0) ? pix[15:8] : pix[7:0];
    endfunction

    task automatic push_frame(input int m, input logic [15:0] fc, input int n);
        for (int l = 0; l < VV; l++)
            for (int k = 0; k < ACT; k++) q_data.push_back(exp_byte(m, fc, k));
        q_fc.push_back(16'(n));
    endtask

    task automatic chk_quiet(input string tag, input int fc);
        chk({tag, "_vsync"}, vsync, 0);
        chk({tag, "_href"}, href, 0);
        chk({tag, "_data"}, data, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, fc);
    endtask

    // Monitor: scoreboard pops on href bytes and frame_done, plus sync timing checks
    int   mcyc = 0, vs_run = 0, hr_run = 0, t_vs = -1, t_fall = -1, t_fd = -1;
    logic p_vs = 1'b0, p_hr = 1'b0, first_hr = 1'b0;
    always @(negedge sys_clk) begin
        mcyc++;
        if (!sys_rst_n) begin
            vs_run = 0; hr_run = 0; t_vs = -1; t_fall = -1; t_fd = -1;
            p_vs = 1'b0; p_hr = 1'b0; first_hr = 1'b0;
        end else begin
            if (href) begin
                if (q_data.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL data: byte %0h with href but no expected byte queued", data);
                end else chk("data", data, q_data.pop_front());
            end else chk("data_blank", data, 0);
            if (frame_done) begin
                if (q_fc.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL frame_done: pulse with frame_cnt %0h but none expected", frame_cnt);
                end else chk("frame_cnt", frame_cnt, q_fc.pop_front());
                if (t_vs >= 0) chk("frame_done_pos", mcyc - t_vs, FRAME - 1);
                if (t_fd >= 0) chk("frame_done_spacing", mcyc - t_fd, FRAME);
                t_fd = mcyc;
            end
            if (vsync && !p_vs) begin
                t_vs = mcyc;
                first_hr = 1'b1;
            end
            if (vsync) vs_run++;
            else begin
                if (p_vs) chk("vsync_len", vs_run, VS * LINE);
                vs_run = 0;
            end
            if (href && !p_hr) begin
                if (first_hr) begin
                    chk("href_first", mcyc - t_vs, (VS + VB) * LINE);
                    first_hr = 1'b0;
                end else if (t_fall >= 0) chk("href_gap", mcyc - t_fall, LINE - ACT);
            end
            if (href) hr_run++;
            else begin
                if (p_hr) begin
                    chk("href_len", hr_run, ACT);
                    t_fall = mcyc;
                end
                hr_run = 0;
            end
            p_vs = vsync;
            p_hr = href;
        end
    end

    // Stimulus: each frame's expectation is queued before that frame begins
    initial begin
        repeat (3) @(posedge sys_clk);
        #1;
        chk_quiet("reset", 0);
        chk("reset_frame_done", frame_done, 0);
        sys_rst_n = 1'b1;
        repeat (5) @(posedge sys_clk);
        #1;
        chk_quiet("idle", 0);
        push_frame(0, 16'h0000, 1);
        mode = 2'd0;
        enable = 1'b1;
        repeat (1000) @(posedge sys_clk);
        #1;
        mode = 2'd3;
        fixed_color = 16'h1234;
        push_frame(3, 16'h1234, 2);
        repeat (FRAME) @(posedge sys_clk);
        #1;
        mode = 2'd1;
        fixed_color = 16'hABCD;
        push_frame(1, 16'hABCD, 3);
        repeat (FRAME) @(posedge sys_clk);
        #1;
        mode = 2'd2;
        push_frame(2, 16'hABCD, 4);
        repeat (FRAME) @(posedge sys_clk);
        #1;
        enable = 1'b0;
        repeat (FRAME + 20) @(posedge sys_clk);
        #1;
        chk_quiet("after_stop", 4);
        chk("queue_drained", q_data.size(), 0);
        repeat (500) @(posedge sys_clk);
        #1;
        chk_quiet("held_idle", 4);
        mode = 2'd0;
        push_frame(0, 16'hABCD, 5);
        enable = 1'b1;
        repeat (LINE * 4 + 100) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("href_before_reset", href, 1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk_quiet("mid_line_reset", 0);
        chk("mid_line_reset_frame_done", frame_done, 0);
        q_data.delete();
        q_fc.delete();
        repeat (3) @(posedge sys_clk);
        #1;
        push_frame(0, 16'hABCD, 1);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (LINE) @(posedge sys_clk);
        #1;
        chk("vsync_after_reset", vsync, 1);
        repeat (800) @(posedge sys_clk);
        #1;
        enable = 1'b0;
        repeat (FRAME) @(posedge sys_clk);
        #1;
        chk_quiet("final", 1);
        chk("final_data_queue", q_data.size(), 0);
        chk("final_fc_queue", q_fc.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
